cordic_atan: RTL

CORDIC_ATAN -- requirements
Module: cordic_atan

---
 rtl/cordic_atan.sv | 109 ++++++++++
 1 files changed

// File: rtl/cordic_atan.sv
// Vectoring CORDIC: converts one I/Q sample into a 32-bit phase and an uncorrected magnitude,
// iterating once per clock through an IDLE/ROT/DONE handshake FSM.
module cordic_atan #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] t_iq_dat,
  input  logic        t_iq_req,
  output logic        t_iq_ack,
  output logic [31:0] i_angle_dat,
  output logic [15:0] i_mag_dat,
  output logic        i_angle_req,
  input  logic        i_angle_ack
);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  // round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [31:0] ATAN_TAB [16] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861
  };

  state_t             state, state_nxt;
  logic signed [19:0] x, y, x_nxt, y_nxt;
  logic [31:0]        z, z_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               zero, zero_nxt;

  logic signed [15:0] re, im;
  logic signed [19:0] re_x, im_x, xs, ys;

  assign re   = t_iq_dat[15:0];
  assign im   = t_iq_dat[31:16];
  // 20-bit headroom lets -(-32768) and the CORDIC gain fit without overflow
  assign re_x = {{4{re[15]}}, re};
  assign im_x = {{4{im[15]}}, im};
  assign xs   = x >>> cnt;
  assign ys   = y >>> cnt;

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    z_nxt     = z;
    cnt_nxt   = cnt;
    zero_nxt  = zero;
    case (state)
      IDLE: if (t_iq_req) begin
        state_nxt = ROT;
        cnt_nxt   = '0;
        zero_nxt  = (re == 16'sd0) && (im == 16'sd0);
        // fold the left half-plane onto the right so the iterations converge
        if (re[15]) begin
          x_nxt = -re_x;
          y_nxt = -im_x;
          z_nxt = 32'h8000_0000;
        end else begin
          x_nxt = re_x;
          y_nxt = im_x;
          z_nxt = '0;
        end
      end
      ROT: begin
        if (!y[19]) begin
          x_nxt = x + ys;
          y_nxt = y - xs;
          z_nxt = z + ATAN_TAB[cnt];
        end else begin
          x_nxt = x - ys;
          y_nxt = y + xs;
          z_nxt = z - ATAN_TAB[cnt];
        end
        if (cnt == 4'(ITER - 1)) state_nxt = DONE;
        else                      cnt_nxt   = cnt + 4'd1;
      end
      DONE: if (i_angle_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      cnt   <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      z     <= z_nxt;
      cnt   <= cnt_nxt;
      zero  <= zero_nxt;
    end
  end

  assign t_iq_ack    = (state == IDLE);
  assign i_angle_req = (state == DONE);
  // x is non-negative and below 2^17 after the last iteration
  assign i_angle_dat = (i_angle_req && !zero) ? z         : '0;
  assign i_mag_dat   = (i_angle_req && !zero) ? x[16:1]   : '0;

endmodule
